packet_framer: RTL
==================

PACKET_FRAMER -- requirements
Module: packet_framer

Interface
REQ-001 SHALL have parameter MAX_LENGTH, default 255, the maximum number of payload bytes per frame (legal range 1..255).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 SHALL have port packet_data  input  8  payload byte of the incoming packet stream.
REQ-005 SHALL have port packet_valid  input  1  packet_data/packet_last valid.
REQ-006 SHALL have port packet_ready  output  1  framer accepts the current byte.
REQ-007 SHALL have port packet_last  input  1  current byte ends its packet.
REQ-008 SHALL have port uart_data  output  8  byte offered to the UART transmitter.
REQ-009 SHALL have port uart_valid  output  1  uart_data valid.
REQ-010 SHALL have port uart_ready  input  1  UART transmitter accepts uart_data.
REQ-011 SHALL have port truncated  output  1  one-cycle pulse when a packet is force-split at MAX_LENGTH.
REQ-012 SHALL have port busy  output  1  high whenever the state is not FILL or the byte count is non-zero.

Function
REQ-013 SHALL use a handshake on each stream in which a transfer occurs only on a cycle where valid and ready are both high; with valid high and ready low, the source holds data, last and valid stable.
REQ-014 SHALL emit each frame as one length byte N (1..MAX_LENGTH) followed by exactly N payload bytes, in arrival order; N=0 is never emitted.
REQ-015 SHALL buffer payload in an internal MAX_LENGTH x 8 store with an 8-bit byte count and an 8-bit read index.
REQ-016 SHALL implement the FSM states FILL, HEADER and PAYLOAD; the reset state is FILL.
REQ-017 SHALL, in FILL, drive packet_ready=1 and uart_valid=0; each accepted byte is written at index count and count increments.
REQ-018 SHALL go from FILL to HEADER on the cycle after accepting a byte with packet_last=1 or a byte that makes count equal MAX_LENGTH.
REQ-019 SHALL, in the forced case (count reaches MAX_LENGTH with packet_last=0), pulse truncated high for exactly one cycle, the cycle after that accept; the remaining bytes form the next frame(s).
REQ-020 SHALL, in HEADER, drive uart_valid=1, uart_data=count and packet_ready=0; on the uart handshake it moves to PAYLOAD with read index=0.
REQ-021 SHALL, in PAYLOAD, drive uart_valid=1, uart_data=buffer[read index] and packet_ready=0; each uart handshake increments the read index.
REQ-022 SHALL, on the handshake with read index=count-1, return to FILL with count=0 on the next cycle.
REQ-023 SHALL give a latency from accepting the last input byte to uart_valid rising (header) of exactly 1 cycle.
REQ-024 SHALL, with uart_ready held high, emit one byte per cycle; a frame of N bytes occupies N+1 consecutive uart transfers.
REQ-025 SHALL ignore packet_valid, including while it is asserted, outside FILL; no input byte is lost or duplicated.
REQ-026 SHALL, in FILL with packet_valid=0, hold uart_valid=0 and keep a partial count indefinitely.
REQ-027 SHALL keep the length byte N equal to count, which never exceeds MAX_LENGTH; no wrap-around for MAX_LENGTH=255.

Reset
REQ-028 SHALL, on reset low, immediately drive state=FILL, count=0, read index=0, uart_valid=0, truncated=0 and busy=0, with packet_ready=1 as the output of FILL.
REQ-029 SHALL, on reset asserted mid-frame (HEADER/PAYLOAD) or mid-fill, discard the partial frame; after release the next accepted byte starts a new frame at index 0.
REQ-030 SHALL leave buffer contents uninitialised by reset, with no observable effect.

Verification
REQ-031 SHALL be verified by: packet 0x11,0x22,0x33 (last on 0x33), uart_ready=1 -> uart bytes 0x03,0x11,0x22,0x33 on 4 consecutive cycles, header 1 cycle after last accept.
REQ-032 SHALL be verified by: single byte 0xA5 with last=1 -> 0x01,0xA5; packet_ready low for 2 cycles, then high.
REQ-033 SHALL be verified by: MAX_LENGTH=4, packet 0x01..0x06 (last on 0x06) -> frames 0x04,0x01,0x02,0x03,0x04 then 0x02,0x05,0x06; truncated pulses exactly once.
REQ-034 SHALL be verified by: packet 0x10,0x20 with uart_ready toggling 1/0 each cycle -> output 0x02,0x10,0x20 held stable while stalled, with no duplicates.
REQ-035 SHALL be verified by: reset pulsed low during the PAYLOAD of frame 0x03,0xAA,0xBB,0xCC after 0xAA is sent -> uart_valid=0 immediately; a following packet 0x77 (last) -> 0x01,0x77.
REQ-036 SHALL be verified by: packet_valid held high in HEADER/PAYLOAD -> no acceptance, and packet_ready=0 throughout that period.

Source files
------------

// File: rtl/packet_framer.sv
// packet_framer
//
// Collects an incoming byte stream into frames of at most MAX_LENGTH bytes
// and replays each frame to a UART transmitter as a length byte N followed
// by the N payload bytes in arrival order. A packet longer than MAX_LENGTH
// is split: every full chunk becomes its own frame and `truncated` pulses
// once per forced split.
//
// Ports
//   clock         single clock, rising edge
//   reset         asynchronous, active-low
//   packet_data   input payload byte
//   packet_valid  packet_data / packet_last valid
//   packet_ready  framer accepts the current byte (only while filling)
//   packet_last   current byte ends its packet
//   uart_data     byte offered to the UART (length byte, then payload)
//   uart_valid    uart_data valid
//   uart_ready    UART accepts uart_data
//   truncated     one-cycle pulse after a forced split at MAX_LENGTH
//   busy          high whenever a frame is partially filled or draining
//
// The framer is half-duplex: it either fills the buffer or drains it, never
// both, so input is back-pressured for the whole N+1 byte transmission.

module packet_framer #(
    parameter int MAX_LENGTH = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] packet_data,
    input  logic       packet_valid,
    output logic       packet_ready,
    input  logic       packet_last,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    input  logic       uart_ready,
    output logic       truncated,
    output logic       busy
);

    // Buffer address width; at least one bit so MAX_LENGTH=1 still builds.
    localparam int         AW        = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam logic [7:0] MAX_COUNT = 8'(MAX_LENGTH);

    localparam logic [1:0] FILL    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    logic [1:0] state;
    logic [7:0] count;
    logic [7:0] rd_idx;
    logic [7:0] buffer [MAX_LENGTH];

    logic accept;
    logic count_full;
    logic frame_end;
    logic last_byte;

    assign packet_ready = (state == FILL);
    assign uart_valid   = (state == HEADER) || (state == PAYLOAD);
    assign busy         = (state != FILL) || (count != 8'd0);

    assign accept     = packet_ready && packet_valid;
    // The byte being accepted is the one that fills the buffer. count is
    // always below MAX_COUNT while filling, so count+1 cannot wrap.
    assign count_full = (count + 8'd1) == MAX_COUNT;
    assign frame_end  = packet_last || count_full;
    assign last_byte  = (rd_idx == count - 8'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            count     <= 8'd0;
            rd_idx    <= 8'd0;
            truncated <= 1'b0;
        end else begin
            truncated <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        count <= count + 8'd1;
                        if (frame_end) begin
                            state     <= HEADER;
                            // Forced split: the rest of the packet continues
                            // as a fresh frame once this one has drained.
                            truncated <= count_full && !packet_last;
                        end
                    end
                end
                HEADER: begin
                    if (uart_ready) begin
                        state  <= PAYLOAD;
                        rd_idx <= 8'd0;
                    end
                end
                PAYLOAD: begin
                    if (uart_ready) begin
                        if (last_byte) begin
                            state  <= FILL;
                            count  <= 8'd0;
                            rd_idx <= 8'd0;
                        end else begin
                            rd_idx <= rd_idx + 8'd1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Payload store is deliberately not reset: every entry read in PAYLOAD
    // was written during the preceding FILL, so stale contents never show.
    always_ff @(posedge clock) begin
        if (accept) begin
            buffer[count[AW-1:0]] <= packet_data;
        end
    end

    always_comb begin
        uart_data = 8'h00;
        case (state)
            HEADER:  uart_data = count;
            PAYLOAD: uart_data = buffer[rd_idx[AW-1:0]];
            default: uart_data = 8'h00;
        endcase
    end

endmodule
